cmos_pixel_pack: RTL

Parametrised camera-side pixel assembler: samples the 8-bit (generally IN_W-bit) DVP bus on the sensor pixel clock, packs BPP consecutive bytes into one pixel word with runtime-selectable byte order, crops a rectangular window and tags each output pixel with start-of-frame / end-of-line flags. It sits between the sensor pins and the line FIFO / frame buffer write port. It generalises the fixed 8→16-bit converter to RAW8, RGB565 and RGB888 sources. It adds cropping, frame/line statistics and malformed-line detection.

---
 rtl/cmos_pixel_pack_if.sv | 25 ++
 rtl/cmos_pixel_pack.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cmos_pixel_pack_if.sv
// ---------------------------------------------------------------------------
// cmos_pixel_pack_if
//   Pixel stream leaving the camera-side pixel assembler. It is a plain
//   valid-qualified stream with no back-pressure, because the sensor cannot
//   be stalled.
//
//   pix_o      assembled pixel, holds its last value while pix_vld_o is low
//   pix_vld_o  one-cycle strobe per kept pixel
//   sof_o      first kept pixel of the frame (only meaningful with pix_vld_o)
//   eol_o      last kept pixel of a kept line (only meaningful with pix_vld_o)
//
//   master : producer (cmos_pixel_pack)
//   slave  : consumer (line FIFO / frame buffer write port)
// ---------------------------------------------------------------------------
interface cmos_pixel_pack_if #(
  parameter int PIX_W = 16
);
  logic [PIX_W-1:0] pix_o;
  logic             pix_vld_o;
  logic             sof_o;
  logic             eol_o;

  modport master (output pix_o, pix_vld_o, sof_o, eol_o);
  modport slave  (input  pix_o, pix_vld_o, sof_o, eol_o);
endinterface

// File: rtl/cmos_pixel_pack.sv
// ---------------------------------------------------------------------------
// cmos_pixel_pack
//   Samples a DVP sensor bus on pclk, packs BPP consecutive beats into one
//   pixel word (MSB-first, or LSB-first when swap is latched), crops a
//   rectangular window and tags kept pixels with start-of-frame and
//   end-of-line flags. It also keeps a frame counter and the length of the
//   most recent line, and flags lines that end with a partial pixel.
//
//   clk          sensor pixel clock; all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   vsync_i      frame sync, active level given by VS_POL
//   href_i       line valid; data_i carries a beat while high
//   data_i       sensor data beat
//   swap_i       byte order, latched at every frame start
//   pix_if       pixel stream out (pix_o / pix_vld_o / sof_o / eol_o)
//   frame_cnt_o  frames started since reset, wraps
//   line_len_o   complete pixels in the most recent line
//   err_o        one-cycle pulse when a line ends with a partial pixel
// ---------------------------------------------------------------------------
module cmos_pixel_pack #(
  parameter int IN_W     = 8,
  parameter int BPP      = 2,
  parameter int CNT_W    = 12,
  parameter int X_START  = 0,
  parameter int X_WIDTH  = 480,
  parameter int Y_START  = 0,
  parameter int Y_HEIGHT = 272,
  parameter bit VS_POL   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vsync_i,
  input  logic                 href_i,
  input  logic [IN_W-1:0]      data_i,
  input  logic                 swap_i,
  cmos_pixel_pack_if.master    pix_if,
  output logic [7:0]           frame_cnt_o,
  output logic [CNT_W-1:0]     line_len_o,
  output logic                 err_o
);

  localparam int PIX_W = IN_W * BPP;
  localparam int PH_W  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BPP - 1);
  localparam int X_END = X_START + X_WIDTH;
  localparam int Y_END = Y_START + Y_HEIGHT;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t            state;
  logic              vs_q;      // registered copy of vsync, normalised to active-high
  logic              href_q;
  logic              swap_q;
  logic [PH_W-1:0]   phase;
  logic [PIX_W-1:0]  acc;
  logic [CNT_W-1:0]  x;
  logic [CNT_W-1:0]  y;

  logic              vs_act;
  logic              frame_start;
  logic              line_end;
  logic              beat;
  logic              pix_done;
  logic              keep;
  logic              is_sof;
  logic              is_eol;
  int                x_int;
  int                y_int;
  int                slot;
  logic [PIX_W-1:0]  acc_next;

  assign vs_act      = VS_POL ? vsync_i : ~vsync_i;
  assign frame_start = vs_act & ~vs_q;
  // A beat that coincides with a frame start belongs to no frame and is
  // discarded together with any partial pixel.
  assign beat        = (state == S_ACTIVE) && href_i && !frame_start;
  assign pix_done    = beat && (phase == PH_LAST);
  assign line_end    = (state == S_ACTIVE) && href_q && !href_i;

  assign x_int  = int'(x);
  assign y_int  = int'(y);
  assign keep   = (x_int >= X_START) && (x_int < X_END) &&
                  (y_int >= Y_START) && (y_int < Y_END);
  assign is_sof = (x_int == X_START) && (y_int == Y_START);
  assign is_eol = (x_int == X_END - 1);

  // Place the incoming beat in its slot. MSB-first puts beat 0 in the top
  // slot; the pixel word is taken from acc_next so the last beat needs no
  // extra cycle.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    acc_next = acc;
    slot     = swap_q ? int'(phase) : (BPP - 1 - int'(phase));
    for (int b = 0; b < BPP; b++) begin
      if (b == slot) acc_next[b*IN_W +: IN_W] = data_i;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      vs_q             <= 1'b0;
      href_q           <= 1'b0;
      swap_q           <= 1'b0;
      phase            <= '0;
      acc              <= '0;
      x                <= '0;
      y                <= '0;
      pix_if.pix_o     <= '0;
      pix_if.pix_vld_o <= 1'b0;
      pix_if.sof_o     <= 1'b0;
      pix_if.eol_o     <= 1'b0;
      frame_cnt_o      <= '0;
      line_len_o       <= '0;
      err_o            <= 1'b0;
    end else begin
      vs_q             <= vs_act;
      href_q           <= href_i;
      pix_if.pix_vld_o <= 1'b0;
      pix_if.sof_o     <= 1'b0;
      pix_if.eol_o     <= 1'b0;
      err_o            <= 1'b0;

      if (frame_start) begin
        // Frame start overrides everything, including a line in progress;
        // the partial pixel is dropped silently.
        state       <= S_ACTIVE;
        frame_cnt_o <= frame_cnt_o + 8'd1;
        swap_q      <= swap_i;
        phase       <= '0;
        x           <= '0;
        y           <= '0;
        if (line_end) line_len_o <= x;
      end else if (state == S_ACTIVE) begin
        if (beat) begin
          acc <= acc_next;
          if (pix_done) begin
            phase <= '0;
            x     <= (x == '1) ? x : x + 1'b1;
            if (keep) begin
              pix_if.pix_o     <= acc_next;
              pix_if.pix_vld_o <= 1'b1;
              pix_if.sof_o     <= is_sof;
              pix_if.eol_o     <= is_eol;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end else if (line_end) begin
          line_len_o <= x;
          y          <= (y == '1) ? y : y + 1'b1;
          x          <= '0;
          phase      <= '0;
          err_o      <= (phase != '0);
        end
      end
    end
  end

endmodule
